d_format_decoder: RTL and testbench



---
 rtl/d_format_decoder_pkg.sv | 72 +++++++
 rtl/d_format_decoder_lut.sv | 74 +++++++
 rtl/d_format_decoder.sv | 105 ++++++++++
 tb/tb_d_format_decoder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/d_format_decoder_pkg.sv
// Shared decode constants and the D-form decode record used by the format decoders.
package d_format_decoder_pkg;

    localparam int unsigned FMT_W     = 25;
    localparam int unsigned PRIM_OP_W = 6;
    localparam int unsigned FU_W      = 3;
    localparam int unsigned RW_W      = 2;

    localparam logic [FU_W-1:0] FU_FX = 3'd0;
    localparam logic [FU_W-1:0] FU_LS = 3'd4;

    localparam logic [FMT_W-1:0] FMT_D = 25'h000_0020;

    localparam logic [RW_W-1:0] REG_NONE  = 2'b00;
    localparam logic [RW_W-1:0] REG_READ  = 2'b10;
    localparam logic [RW_W-1:0] REG_WRITE = 2'b01;
    localparam logic [RW_W-1:0] REG_RW    = 2'b11;

    localparam logic [PRIM_OP_W-1:0] OP_TDI      = 6'd2;
    localparam logic [PRIM_OP_W-1:0] OP_TWI      = 6'd3;
    localparam logic [PRIM_OP_W-1:0] OP_MULLI    = 6'd7;
    localparam logic [PRIM_OP_W-1:0] OP_SUBFIC   = 6'd8;
    localparam logic [PRIM_OP_W-1:0] OP_CMPLI    = 6'd10;
    localparam logic [PRIM_OP_W-1:0] OP_CMPI     = 6'd11;
    localparam logic [PRIM_OP_W-1:0] OP_ADDIC    = 6'd12;
    localparam logic [PRIM_OP_W-1:0] OP_ADDIC_RC = 6'd13;
    localparam logic [PRIM_OP_W-1:0] OP_ADDI     = 6'd14;
    localparam logic [PRIM_OP_W-1:0] OP_ADDIS    = 6'd15;
    localparam logic [PRIM_OP_W-1:0] OP_ORI      = 6'd24;
    localparam logic [PRIM_OP_W-1:0] OP_ORIS     = 6'd25;
    localparam logic [PRIM_OP_W-1:0] OP_XORI     = 6'd26;
    localparam logic [PRIM_OP_W-1:0] OP_XORIS    = 6'd27;
    localparam logic [PRIM_OP_W-1:0] OP_ANDI_RC  = 6'd28;
    localparam logic [PRIM_OP_W-1:0] OP_ANDIS_RC = 6'd29;
    localparam logic [PRIM_OP_W-1:0] OP_LWZ      = 6'd32;
    localparam logic [PRIM_OP_W-1:0] OP_LWZU     = 6'd33;
    localparam logic [PRIM_OP_W-1:0] OP_LBZ      = 6'd34;
    localparam logic [PRIM_OP_W-1:0] OP_LBZU     = 6'd35;
    localparam logic [PRIM_OP_W-1:0] OP_STW      = 6'd36;
    localparam logic [PRIM_OP_W-1:0] OP_STWU     = 6'd37;
    localparam logic [PRIM_OP_W-1:0] OP_STB      = 6'd38;
    localparam logic [PRIM_OP_W-1:0] OP_STBU     = 6'd39;
    localparam logic [PRIM_OP_W-1:0] OP_LHZ      = 6'd40;
    localparam logic [PRIM_OP_W-1:0] OP_LHZU     = 6'd41;
    localparam logic [PRIM_OP_W-1:0] OP_LHA      = 6'd42;
    localparam logic [PRIM_OP_W-1:0] OP_LHAU     = 6'd43;
    localparam logic [PRIM_OP_W-1:0] OP_STH      = 6'd44;
    localparam logic [PRIM_OP_W-1:0] OP_STHU     = 6'd45;
    localparam logic [PRIM_OP_W-1:0] OP_LMW      = 6'd46;
    localparam logic [PRIM_OP_W-1:0] OP_STMW     = 6'd47;
    localparam logic [PRIM_OP_W-1:0] OP_LFS      = 6'd48;
    localparam logic [PRIM_OP_W-1:0] OP_LFSU     = 6'd49;
    localparam logic [PRIM_OP_W-1:0] OP_LFD      = 6'd50;
    localparam logic [PRIM_OP_W-1:0] OP_LFDU     = 6'd51;
    localparam logic [PRIM_OP_W-1:0] OP_STFS     = 6'd52;
    localparam logic [PRIM_OP_W-1:0] OP_STFSU    = 6'd53;
    localparam logic [PRIM_OP_W-1:0] OP_STFD     = 6'd54;
    localparam logic [PRIM_OP_W-1:0] OP_STFDU    = 6'd55;

    typedef struct packed {
        logic            valid;
        logic [FU_W-1:0] fu;
        logic [RW_W-1:0] rw1;
        logic [RW_W-1:0] rw2;
        logic            is_reg1;
        logic            is_reg2;
        logic            ext;
        logic            shift;
        logic            cr;
    } d_decode_t;

endpackage

// File: rtl/d_format_decoder_lut.sv
// Combinational primary-opcode lookup for the 40 D-form instructions.
module d_form_opcode_lut
    import d_format_decoder_pkg::*;
(
    input  logic [PRIM_OP_W-1:0] i_opcode,
    output d_decode_t            o_decode_c
);

    always_comb begin
        o_decode_c = '{valid: 1'b0, fu: FU_FX, rw1: REG_NONE, rw2: REG_NONE,
                       is_reg1: 1'b1, is_reg2: 1'b1, ext: 1'b0, shift: 1'b0, cr: 1'b0};
        case (i_opcode)
            OP_TDI, OP_TWI: begin
                o_decode_c.valid   = 1'b1;
                o_decode_c.is_reg1 = 1'b0;
                o_decode_c.rw2     = REG_READ;
                o_decode_c.ext     = 1'b1;
            end
            OP_MULLI, OP_SUBFIC, OP_ADDIC, OP_ADDIC_RC, OP_ADDI, OP_ADDIS: begin
                o_decode_c.valid = 1'b1;
                o_decode_c.rw1   = REG_WRITE;
                o_decode_c.rw2   = REG_READ;
                o_decode_c.ext   = 1'b1;
                o_decode_c.shift = (i_opcode == OP_ADDIS);
                o_decode_c.cr    = (i_opcode == OP_ADDIC_RC);
            end
            OP_CMPLI, OP_CMPI: begin
                o_decode_c.valid   = 1'b1;
                o_decode_c.is_reg1 = 1'b0;
                o_decode_c.rw2     = REG_READ;
                o_decode_c.cr      = 1'b1;
                o_decode_c.ext     = (i_opcode == OP_CMPI);
            end
            // Logical immediates: RS is the source, RA the destination; odd opcodes take the high half.
            OP_ORI, OP_ORIS, OP_XORI, OP_XORIS, OP_ANDI_RC, OP_ANDIS_RC: begin
                o_decode_c.valid = 1'b1;
                o_decode_c.rw1   = REG_READ;
                o_decode_c.rw2   = REG_WRITE;
                o_decode_c.shift = i_opcode[0];
                o_decode_c.cr    = (i_opcode == OP_ANDI_RC) || (i_opcode == OP_ANDIS_RC);
            end
            OP_LWZ, OP_LBZ, OP_LHZ, OP_LHA, OP_LMW, OP_LFS, OP_LFD: begin
                o_decode_c.valid = 1'b1;
                o_decode_c.fu    = FU_LS;
                o_decode_c.rw1   = REG_WRITE;
                o_decode_c.rw2   = REG_READ;
                o_decode_c.ext   = 1'b1;
            end
            OP_LWZU, OP_LBZU, OP_LHZU, OP_LHAU, OP_LFSU, OP_LFDU: begin
                o_decode_c.valid = 1'b1;
                o_decode_c.fu    = FU_LS;
                o_decode_c.rw1   = REG_WRITE;
                o_decode_c.rw2   = REG_RW;
                o_decode_c.ext   = 1'b1;
            end
            OP_STW, OP_STB, OP_STH, OP_STMW, OP_STFS, OP_STFD: begin
                o_decode_c.valid = 1'b1;
                o_decode_c.fu    = FU_LS;
                o_decode_c.rw1   = REG_READ;
                o_decode_c.rw2   = REG_READ;
                o_decode_c.ext   = 1'b1;
            end
            OP_STWU, OP_STBU, OP_STHU, OP_STFSU, OP_STFDU: begin
                o_decode_c.valid = 1'b1;
                o_decode_c.fu    = FU_LS;
                o_decode_c.rw1   = REG_READ;
                o_decode_c.rw2   = REG_RW;
                o_decode_c.ext   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/d_format_decoder.sv
// D-form instruction decoder: one registered stage from fetched instruction to micro-op header/body.
module d_format_decoder
    import d_format_decoder_pkg::*;
#(
    parameter int unsigned addressWidth            = 64,
    parameter int unsigned instructionWidth        = 32,
    parameter int unsigned PidSize                 = 20,
    parameter int unsigned TidSize                 = 16,
    parameter int unsigned instructionCounterWidth = 64,
    parameter int unsigned instMinIdWidth          = 5,
    parameter int unsigned opcodeSize              = 12,
    parameter int unsigned PrimOpcodeSize          = 6,
    parameter int unsigned regSize                 = 5,
    parameter int unsigned immediateSize           = 16,
    parameter int unsigned funcUnitCodeSize        = 3
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               enable_i,
    input  logic                               stall_i,
    input  logic [FMT_W-1:0]                   instFormat_i,
    input  logic [PrimOpcodeSize-1:0]          instructionOpcode_i,
    input  logic [instructionWidth-1:0]        instruction_i,
    input  logic [addressWidth-1:0]            instructionAddress_i,
    input  logic                               is64Bit_i,
    input  logic [PidSize-1:0]                 instructionPid_i,
    input  logic [TidSize-1:0]                 instructionTid_i,
    input  logic [instructionCounterWidth-1:0] instructionMajId_i,
    output logic                               enable_o,
    output logic [opcodeSize-1:0]              opcode_o,
    output logic [addressWidth-1:0]            instructionAddress_o,
    output logic [instructionCounterWidth-1:0] instMajId_o,
    output logic                               is64Bit_o,
    output logic [PidSize-1:0]                 instPid_o,
    output logic [TidSize-1:0]                 instTid_o,
    output logic [funcUnitCodeSize-1:0]        functionalUnitType_o,
    output logic [instMinIdWidth-1:0]          instMinId_o,
    output logic [instMinIdWidth-1:0]          numMicroOps_o,
    output logic [1:0]                         op1rw_o,
    output logic [1:0]                         op2rw_o,
    output logic                               op1isReg_o,
    output logic                               op2isReg_o,
    output logic                               immIsExtended_o,
    output logic                               immIsShifted_o,
    output logic                               modifiesCR_o,
    output logic [2*regSize+immediateSize-1:0] instructionBody_o
);

    d_decode_t w_decode;
    logic      w_valid;
    logic      w_unused_opcode_bits;

    d_form_opcode_lut u_lut (
        .i_opcode   (instructionOpcode_i),
        .o_decode_c (w_decode)
    );

    assign w_valid = enable_i && (instFormat_i == FMT_D) && w_decode.valid;

    // The primary opcode arrives on its own port; the copy inside the instruction word is not needed.
    assign w_unused_opcode_bits = ^instruction_i[instructionWidth-1 -: PrimOpcodeSize];

    assign instMinId_o   = '0;
    assign numMicroOps_o = '0;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            enable_o             <= 1'b0;
            opcode_o             <= '0;
            instructionAddress_o <= '0;
            instMajId_o          <= '0;
            is64Bit_o            <= 1'b0;
            instPid_o            <= '0;
            instTid_o            <= '0;
            functionalUnitType_o <= '0;
            op1rw_o              <= '0;
            op2rw_o              <= '0;
            op1isReg_o           <= 1'b0;
            op2isReg_o           <= 1'b0;
            immIsExtended_o      <= 1'b0;
            immIsShifted_o       <= 1'b0;
            modifiesCR_o         <= 1'b0;
            instructionBody_o    <= '0;
        end else if (!stall_i) begin
            enable_o             <= w_valid;
            opcode_o             <= opcodeSize'(instructionOpcode_i);
            instructionAddress_o <= instructionAddress_i;
            instMajId_o          <= instructionMajId_i;
            is64Bit_o            <= is64Bit_i;
            instPid_o            <= instructionPid_i;
            instTid_o            <= instructionTid_i;
            functionalUnitType_o <= funcUnitCodeSize'(w_decode.fu);
            op1rw_o              <= w_decode.rw1;
            op2rw_o              <= w_decode.rw2;
            op1isReg_o           <= w_decode.is_reg1;
            op2isReg_o           <= w_decode.is_reg2;
            immIsExtended_o      <= w_decode.ext;
            immIsShifted_o       <= w_decode.shift;
            modifiesCR_o         <= w_decode.cr;
            // Big-endian bit numbering: fields 6:10, 11:15, 16:31 are the low 26 bits.
            instructionBody_o    <= instruction_i[2*regSize+immediateSize-1:0];
        end
    end

endmodule

// File: tb/tb_d_format_decoder.sv
// Scoreboard bench for d_format_decoder: directed D-form vectors, opcode sweep, stall and reset.
module tb_d_format_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable_i = 1'b0, stall_i = 1'b0, is64_i = 1'b0;
    logic [24:0] fmt_i = '0;
    logic [5:0]  prim_i = '0;
    logic [31:0] instr_i = '0;
    logic [63:0] addr_i = '0, maj_i = '0;
    logic [19:0] pid_i = '0;
    logic [15:0] tid_i = '0;

    logic        enable_o, is64_o, r1_o, r2_o, ext_o, sh_o, cr_o;
    logic [11:0] opcode_o;
    logic [63:0] addr_o, maj_o;
    logic [19:0] pid_o;
    logic [15:0] tid_o;
    logic [2:0]  fu_o;
    logic [4:0]  minid_o, nmops_o;
    logic [1:0]  rw1_o, rw2_o;
    logic [25:0] body_o;

    localparam logic [24:0] FD = 25'h000_0020;

    d_format_decoder dut (
        .clock_i(clk), .reset_i(rst), .enable_i(enable_i), .stall_i(stall_i),
        .instFormat_i(fmt_i), .instructionOpcode_i(prim_i), .instruction_i(instr_i),
        .instructionAddress_i(addr_i), .is64Bit_i(is64_i), .instructionPid_i(pid_i),
        .instructionTid_i(tid_i), .instructionMajId_i(maj_i),
        .enable_o(enable_o), .opcode_o(opcode_o), .instructionAddress_o(addr_o),
        .instMajId_o(maj_o), .is64Bit_o(is64_o), .instPid_o(pid_o), .instTid_o(tid_o),
        .functionalUnitType_o(fu_o), .instMinId_o(minid_o), .numMicroOps_o(nmops_o),
        .op1rw_o(rw1_o), .op2rw_o(rw2_o), .op1isReg_o(r1_o), .op2isReg_o(r2_o),
        .immIsExtended_o(ext_o), .immIsShifted_o(sh_o), .modifiesCR_o(cr_o),
        .instructionBody_o(body_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] opc;
        logic [2:0]  fu;
        logic [1:0]  rw1, rw2;
        logic        r1, r2, ext, sh, cr;
        logic [25:0] body;
        logic [63:0] addr, maj;
        logic [19:0] pid;
        logic [15:0] tid;
        logic        is64;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_fail = 0, n_sweep = 0, seq = 0;
    bit   sb_on = 1'b0, sweep_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int opc, input logic [2:0] fu, input logic [1:0] rw1,
                                input logic [1:0] rw2, input logic r1, input logic r2,
                                input logic ext, input logic sh, input logic cr,
                                input logic [25:0] body);
        exp_t e;
        e = '{opc: 12'(opc), fu: fu, rw1: rw1, rw2: rw2, r1: r1, r2: r2, ext: ext, sh: sh,
              cr: cr, body: body, addr: '0, maj: '0, pid: '0, tid: '0, is64: 1'b0};
        return e;
    endfunction

    task automatic drive(input logic [31:0] instr, input logic [24:0] fmt);
        enable_i = 1'b1;
        fmt_i    = fmt;
        instr_i  = instr;
        prim_i   = instr[31:26];
        addr_i   = 64'h0000_7F00_0000_0000 + 64'(seq) * 64'd4;
        pid_i    = 20'h12345 + 20'(seq);
        tid_i    = 16'hBEE0 + 16'(seq);
        maj_i    = 64'd100 + 64'(seq);
        is64_i   = seq[0];
    endtask

    task automatic issue(input logic [31:0] instr, input logic [24:0] fmt, input bit push, input exp_t e);
        @(posedge clk); #1;
        drive(instr, fmt);
        if (push) begin
            e.addr = addr_i; e.maj = maj_i; e.pid = pid_i; e.tid = tid_i; e.is64 = is64_i;
            q.push_back(e);
        end
        seq++;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        enable_i = 1'b0;
    endtask

    // Monitor: pops one expectation per valid output, flags valids nobody asked for.
    always @(negedge clk) begin
        if (sweep_on && enable_o) n_sweep++;
        if (sb_on && !rst && enable_o) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 64'(enable_o), 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("opcode", 64'(opcode_o), 64'(e.opc));
                chk("fu", 64'(fu_o), 64'(e.fu));
                chk("op1rw", 64'(rw1_o), 64'(e.rw1));
                chk("op2rw", 64'(rw2_o), 64'(e.rw2));
                chk("op1isReg", 64'(r1_o), 64'(e.r1));
                chk("op2isReg", 64'(r2_o), 64'(e.r2));
                chk("immExt", 64'(ext_o), 64'(e.ext));
                chk("immShift", 64'(sh_o), 64'(e.sh));
                chk("modCR", 64'(cr_o), 64'(e.cr));
                chk("body", 64'(body_o), 64'(e.body));
                chk("address", addr_o, e.addr);
                chk("majid", maj_o, e.maj);
                chk("pid", 64'(pid_o), 64'(e.pid));
                chk("tid", 64'(tid_o), 64'(e.tid));
                chk("is64", 64'(is64_o), 64'(e.is64));
                chk("minid", 64'(minid_o), 64'd0);
                chk("nmops", 64'(nmops_o), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t none;
        none = mk(0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 26'd0);

        // Reset holds every output at zero even with a valid op presented.
        #2 rst = 1'b1;
        @(posedge clk); #1;
        drive(32'h3861FFFF, FD);
        @(negedge clk); @(negedge clk);
        chk("rst_enable", 64'(enable_o), 64'd0);
        chk("rst_opcode", 64'(opcode_o), 64'd0);
        chk("rst_address", addr_o, 64'd0);
        chk("rst_body", 64'(body_o), 64'd0);
        chk("rst_op2rw", 64'(rw2_o), 64'd0);
        chk("rst_pid", 64'(pid_o), 64'd0);
        enable_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle();

        // Back-to-back directed vectors through the scoreboard.
        sb_on = 1'b1;
        issue(32'h3861FFFF, FD, 1'b1, mk(14, 3'd0, 2'b01, 2'b10, 1, 1, 1, 0, 0, {5'd3, 5'd1, 16'hFFFF}));
        issue(32'h64A50010, FD, 1'b1, mk(25, 3'd0, 2'b10, 2'b01, 1, 1, 0, 1, 0, {5'd5, 5'd5, 16'h0010}));
        issue(32'h9421FFF0, FD, 1'b1, mk(37, 3'd4, 2'b10, 2'b11, 1, 1, 1, 0, 0, {5'd1, 5'd1, 16'hFFF0}));
        issue(32'h2C030005, FD, 1'b1, mk(11, 3'd0, 2'b00, 2'b10, 0, 1, 1, 0, 1, {5'd0, 5'd3, 16'h0005}));
        issue(32'h70640F0F, FD, 1'b1, mk(28, 3'd0, 2'b10, 2'b01, 1, 1, 0, 0, 1, {5'd3, 5'd4, 16'h0F0F}));
        issue(32'h84A60008, FD, 1'b1, mk(33, 3'd4, 2'b01, 2'b11, 1, 1, 1, 0, 0, {5'd5, 5'd6, 16'h0008}));
        issue(32'h0C810010, FD, 1'b1, mk(3, 3'd0, 2'b00, 2'b10, 0, 1, 1, 0, 0, {5'd4, 5'd1, 16'h0010}));
        issue(32'h3C60ABCD, FD, 1'b1, mk(15, 3'd0, 2'b01, 2'b10, 1, 1, 1, 1, 0, {5'd3, 5'd0, 16'hABCD}));
        issue(32'h34A3FFFE, FD, 1'b1, mk(13, 3'd0, 2'b01, 2'b10, 1, 1, 1, 0, 1, {5'd5, 5'd3, 16'hFFFE}));
        issue(32'h28040020, FD, 1'b1, mk(10, 3'd0, 2'b00, 2'b10, 0, 1, 0, 0, 1, {5'd0, 5'd4, 16'h0020}));
        // lwz under a non-D format and an unused opcode under D must both stay silent.
        issue(32'h80610004, 25'h000_0010, 1'b0, none);
        issue(32'h10000000, FD, 1'b0, none);
        idle();
        for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
        chk("drain", 64'(q.size()), 64'd0);
        @(negedge clk);
        chk("enable_drop", 64'(enable_o), 64'd0);
        sb_on = 1'b0;

        // Sweep all primary opcodes in D format.
        sweep_on = 1'b1;
        for (int op = 0; op < 64; op++) begin
            @(posedge clk); #1;
            drive({6'(op), 26'h0}, FD);
        end
        idle();
        repeat (3) @(negedge clk);
        sweep_on = 1'b0;
        chk("sweep_count", 64'(n_sweep), 64'd40);

        // Stall freezes a valid addi while new inputs arrive.
        issue(32'h3861FFFF, FD, 1'b0, none);
        @(posedge clk); #1;
        stall_i = 1'b1;
        drive(32'h9421FFF0, FD);
        @(negedge clk);
        chk("stall_base_enable", 64'(enable_o), 64'd1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("stall_enable", 64'(enable_o), 64'd1);
            chk("stall_opcode", 64'(opcode_o), 64'd14);
            chk("stall_body", 64'(body_o), 64'(26'h061FFFF));
            chk("stall_op2rw", 64'(rw2_o), 64'(2'b10));
            @(posedge clk); #1;
            drive(32'h64A50010, FD);
        end

        // Reset mid-stall clears outputs without waiting for a clock edge.
        #1 rst = 1'b1;
        #1;
        chk("async_rst_enable", 64'(enable_o), 64'd0);
        chk("async_rst_opcode", 64'(opcode_o), 64'd0);
        chk("async_rst_body", 64'(body_o), 64'd0);
        chk("async_rst_address", addr_o, 64'd0);
        chk("async_rst_op1rw", 64'(rw1_o), 64'd0);
        @(negedge clk);
        chk("rst_hold_enable", 64'(enable_o), 64'd0);
        stall_i  = 1'b0;
        enable_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
